// File: rtl/axi5_sram_ctrl.sv
// axi5_sram_ctrl: AXI5 slave front-end for a single-port byte-enable on-chip SRAM
module axi5_sram_ctrl #(
    parameter int              XLEN      = 32,
    parameter int              ALEN      = 32,
    parameter int              ILEN      = 4,
    parameter logic [ALEN-1:0] BASE_ADDR = '0,
    parameter int              SIZE      = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            aw_valid,
    output logic            aw_ready,
    input  logic [ILEN-1:0] aw_id,
    input  logic [ALEN-1:0] aw_addr,
    input  logic [7:0]      aw_len,
    input  logic [2:0]      aw_size,
    input  logic [1:0]      aw_burst,
    input  logic            w_valid,
    output logic            w_ready,
    input  logic [XLEN-1:0] w_data,
    input  logic [XLEN/8-1:0] w_strb,
    input  logic            w_last,
    output logic            b_valid,
    input  logic            b_ready,
    output logic [ILEN-1:0] b_id,
    output logic [1:0]      b_resp,
    input  logic            ar_valid,
    output logic            ar_ready,
    input  logic [ILEN-1:0] ar_id,
    input  logic [ALEN-1:0] ar_addr,
    input  logic [7:0]      ar_len,
    input  logic [2:0]      ar_size,
    input  logic [1:0]      ar_burst,
    output logic            r_valid,
    input  logic            r_ready,
    output logic [XLEN-1:0] r_data,
    output logic [ILEN-1:0] r_id,
    output logic            r_last,
    output logic [1:0]      r_resp
);
    localparam int BPW    = XLEN / 8;
    localparam int OFS    = $clog2(BPW);
    localparam int DEPTH  = SIZE / BPW;
    localparam int ADR_SZ = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RDATA, WDATA, BRESP} state_t;

    state_t          state, state_nx;
    logic [ILEN-1:0] id;
    logic [ALEN-1:0] addr, next_addr, incr, mask;
    logic [7:0]      len, cnt;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic            err, last_wr;
    logic            grant_rd, grant_wr, cur_err, rd_en, we;
    logic [ADR_SZ-1:0] sram_idx;
    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] rdata;

    function automatic logic burst_bad(input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        return (int'(s) > OFS) || (b == 2'd3) || (b == 2'd2 && !(l inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic addr_bad(input logic [ALEN-1:0] a);
        return (a - BASE_ADDR) >= ALEN'(SIZE);
    endfunction

    function automatic logic [ADR_SZ-1:0] idx(input logic [ALEN-1:0] a);
        return ADR_SZ'((a - BASE_ADDR) >> OFS);
    endfunction

    assign grant_rd  = state == IDLE && ar_valid && (!aw_valid || last_wr);
    assign grant_wr  = state == IDLE && aw_valid && !grant_rd;
    assign incr      = ALEN'(1) << size;
    assign mask      = ((ALEN'(len) + ALEN'(1)) << size) - ALEN'(1);
    assign next_addr = burst == 2'd0 ? addr :
                       burst == 2'd2 ? (addr & ~mask) | ((addr + incr) & mask) : addr + incr;
    assign cur_err   = burst_bad(len, size, burst) || addr_bad(addr);
    assign sram_idx  = state == IDLE ? idx(ar_addr) : state == WDATA ? idx(addr) : idx(next_addr);
    assign rd_en     = grant_rd ? !(burst_bad(ar_len, ar_size, ar_burst) || addr_bad(ar_addr)) :
                       state == RDATA && r_ready && !r_last && !(burst_bad(len, size, burst) || addr_bad(next_addr));
    assign we        = state == WDATA && w_valid && !cur_err;

    assign r_last = state == RDATA && cnt == len;
    assign r_data = (state == RDATA && !cur_err) ? rdata : '0;
    assign r_resp = (state == RDATA && (err || cur_err)) ? 2'b10 : 2'b00;
    assign r_id   = id;
    assign b_id   = id;
    assign b_resp = (state == BRESP && err) ? 2'b10 : 2'b00;

    // state register; reset abandons any burst in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state and channel handshakes
    always_comb begin
        state_nx = state;
        aw_ready = 1'b0;
        ar_ready = 1'b0;
        w_ready  = 1'b0;
        r_valid  = 1'b0;
        b_valid  = 1'b0;
        case (state)
            IDLE: begin
                ar_ready = grant_rd;
                aw_ready = grant_wr;
                state_nx = grant_rd ? RDATA : grant_wr ? WDATA : IDLE;
            end
            RDATA: begin
                r_valid = 1'b1;
                if (r_ready && r_last) state_nx = IDLE;
            end
            WDATA: begin
                w_ready = 1'b1;
                if (w_valid && (w_last || cnt == len)) state_nx = BRESP;
            end
            BRESP: begin
                b_valid = 1'b1;
                if (b_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // latch the granted request, then step address/count/sticky error per beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id      <= '0;
            addr    <= '0;
            len     <= '0;
            size    <= '0;
            burst   <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            last_wr <= 1'b1;
        end else if (grant_rd || grant_wr) begin
            id      <= grant_rd ? ar_id : aw_id;
            addr    <= grant_rd ? ar_addr : aw_addr;
            len     <= grant_rd ? ar_len : aw_len;
            size    <= grant_rd ? ar_size : aw_size;
            burst   <= grant_rd ? ar_burst : aw_burst;
            cnt     <= '0;
            err     <= 1'b0;
            last_wr <= grant_wr;
        end else if ((state == RDATA && r_ready) || (state == WDATA && w_valid)) begin
            addr <= next_addr;
            cnt  <= cnt + 8'd1;
            err  <= err || cur_err;
        end
    end

    // byte-enable write port of the SRAM array
    always_ff @(posedge clk) begin
        for (int i = 0; i < BPW; i++)
            if (we && w_strb[i]) mem[sram_idx][8*i +: 8] <= w_data[8*i +: 8];
    end

    // SRAM read port: one-cycle latency, output held while not enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata <= '0;
        else if (rd_en) rdata <= mem[sram_idx];
    end
endmodule

// File: doc/axi5_sram_ctrl.md
# axi5_sram_ctrl

AXI5 slave memory controller with full read and write burst support, byte strobes, and address decode against a parameterised window. It sits behind the interconnect as an on-chip SRAM target. It wraps a single-port byte-enable SRAM and serialises read and write bursts with fair arbitration. It sustains one data beat per cycle on both channels.

## Interface
- BASE_ADDR, 0: byte address of the first memory location.
- SIZE, 4096: memory size in bytes; power of two and a multiple of xlen/8.
- Derived (not overridable): BPW = xlen/8 bytes per word, OFS = log2(BPW), DEPTH = SIZE/BPW, ADR_SZ = log2(DEPTH); xlen, alen and ilen come from the interface.
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- axi  axi5.slave  -  AXI5 slave port: aw, w, b, ar, r channels with valid/ready.
- Internal: one byte-enable single-port SRAM, DEPTH x xlen, 1-cycle read latency. rdata holds its value when en=0.

## Operation
- FSM states: IDLE, RDATA, WDATA, BRESP.
- IDLE arbitration:
  - ar_valid only: grant read.
  - aw_valid only: grant write.
  - Both valid: grant the side not granted last time. After reset, read wins.
- Read grant:
  - ar_ready=1 for one cycle; latch id, addr, len, size, burst.
  - Issue the SRAM read of beat 0 in the same cycle; go to RDATA.
- RDATA:
  - r_valid=1, r.data=rdata, r.id=latched id, r.last=(cnt==len), r.resp=OKAY or SLVERR.
  - On r_ready with !last: advance the address, issue the next SRAM read, increment cnt.
  - On r_ready with last: go to IDLE.
- Write grant:
  - aw_ready=1 for one cycle; latch the AW fields; go to WDATA.
  - W beats are not accepted in IDLE.
- WDATA:
  - w_ready=1.
  - On each w_valid beat: SRAM write with byte enables = w.strb, data = w.data, at the current address; advance the address.
  - w.last, or cnt==len, ends the burst and moves to BRESP.
  - The error flag is sticky across the burst.
- BRESP:
  - b_valid=1, b.id=latched id, b.resp=OKAY or SLVERR.
  - On b_ready: go to IDLE.
- Address advance, per burst type:
  - FIXED: address unchanged.
  - INCR: address += 2^size.
  - WRAP: address += 2^size, wrapping within an aligned block of (len+1)*2^size bytes.
  - Arithmetic is done in alen bits; the SRAM index is (addr-BASE_ADDR)[ADR_SZ+OFS-1:OFS].
- Errors: the burst returns SLVERR on every R beat, or on B, when any of these holds:
  - a beat address is outside [BASE_ADDR, BASE_ADDR+SIZE);
  - 2^size > BPW;
  - burst is reserved;
  - WRAP len is not in {1,3,7,15}.
- Error handling:
  - Errored read beats return data 0 and do not enable the SRAM.
  - Errored write beats are suppressed (we=0) but still consumed, so the handshake completes.
- Narrow transfers: accepted. The master provides lane-correct strb; read data is the full word.

## Timing
- Reset: state=IDLE. aw_ready, w_ready, ar_ready, r_valid, b_valid = 0. r and b payloads = 0. cnt=0, latched AX=0, last-grant=write (so read wins first).
- Reset asserted mid-burst: the burst is abandoned immediately and asynchronously; no B or remaining R is produced.
- Read latency: ar handshake at cycle T gives r_valid at T+1 for beat 0.
  - Back-to-back beats follow at full throughput while r_ready=1.
  - r_ready=0 holds r.data stable (SRAM output held, en=0).
- Write:
  - aw handshake at T; w_ready from T+1; one beat per cycle.
  - Last beat at cycle L gives b_valid at L+1.
- Turnaround: the next ar or aw handshake can occur, at the earliest, in the cycle after the final r or b handshake.
- All ready signals are driven from state and inputs without combinational valid-to-ready loops on the R and B channels.
- cnt is 8 bits and counts 0..len; the 256-beat INCR burst is legal.

## Test plan
- Write single beat: aw addr=BASE+0x10, len=0, size=log2(BPW), strb all-ones, data=0xA5A5_5A5A, then ar to the same address -> b.resp OKAY at L+1; r.data=0xA5A5_5A5A, r.last=1 at T+1.
- INCR 4-beat write of 1,2,3,4 at BASE+0x0, then 4-beat read with r_ready toggled 1,0,1,0... -> read returns 1,2,3,4 in order; r.data stable while stalled; last on beat 3 only.
- WRAP len=3 read starting at BASE+0x8 (BPW=4) -> word indices 2,3,0,1.
- Strobe write of 0xFFFF_FFFF with strb=0b0101 over a word holding 0 -> read gives 0x00FF_00FF.
- Simultaneous ar_valid and aw_valid from reset, repeated twice -> grant order read, write, read, write; ids echoed correctly on r and b.
- Out-of-range cases:
  - Read at BASE+SIZE -> r.resp SLVERR, data 0.
  - INCR write crossing the end -> b.resp SLVERR; in-range beats are written, out-of-range beats are not.
  - Reset asserted in RDATA -> r_valid=0 immediately; next ar is served normally.
